id_inst_hold_buffer: RTL
========================

Name: id_inst_hold_buffer

Overview:
- IF/ID boundary stage between the synchronous-read instruction memory and the decode stage.
- The decode stage contains the opcode decoder and the immediate generator, which takes inst_d[31:7].
- Presents the decode-stage instruction, its PC and a valid bit.
- Preserves the instruction across pipeline stalls, although the block RAM output changes one cycle after the address. Substitutes a NOP on flush.
- Keeps a saturating count of stalled decode cycles for debug.

Parameters:
- NOP_INST, 32'h00000013, instruction presented when the decode slot is empty (addi x0,x0,0).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  advance enable from the hazard unit. 1 = decode slot takes a new instruction. 0 = stall, hold the current one.
- clear  in  1  flush from branch/jump resolution. Empties the decode slot.
- pc_f  in  32  address presented to instruction memory this cycle.
- valid_f  in  1  pc_f is a real fetch. It is 0 from reset until the first fetch.
- imem_rdata  in  32  instruction memory read data. It is the word at the address registered on the previous edge.
- inst_d  out  32  decode-stage instruction. Bits [31:7] feed the immediate generator; bits [6:0] feed the opcode decoder.
- pc_d  out  32  PC of inst_d.
- valid_d  out  1  decode slot holds a real instruction.
- stall_cnt  out  CNT_W  number of edges with valid_d=1, en=0 and clear=0; saturating.

Behaviour:
- State registers: pc_d, valid_d, held_inst[31:0], use_held, stall_cnt.
- inst_d is combinational:
  - valid_d=0 → NOP_INST
  - else use_held=1 → held_inst
  - else → imem_rdata
  - There is no added latency: the word fetched at edge t is visible as inst_d during cycle t+1.
- Reset (rst=1 at edge, highest priority): pc_d=0, valid_d=0, use_held=0, held_inst=0, stall_cnt=0. After reset, inst_d=NOP_INST.
- Edge priority after reset: clear, then en, then hold.
  - clear=1, any en: valid_d<=0, use_held<=0, pc_d<=0, held_inst unchanged. inst_d shows NOP_INST next cycle.
  - clear=0, en=1: pc_d<=pc_f, valid_d<=valid_f, use_held<=0.
  - clear=0, en=0, use_held=0: held_inst<=imem_rdata, use_held<=1. This captures the live word before the memory output moves on. pc_d and valid_d are held.
  - clear=0, en=0, use_held=1: all state held. held_inst is not reloaded, even though imem_rdata changes.
- Consequence: inst_d stays bit-stable for the whole stall, however long it lasts. On the first advance after a stall, inst_d reverts to the live memory output.
- Upstream contract, not checked in RTL: pc_f is held while en=0.
- stall_cnt increments by 1 on each edge with rst=0, clear=0, en=0 and valid_d=1. It saturates at all-ones and does not wrap.
- Simultaneous clear and en=0: flush wins. The slot empties, stall_cnt does not increment, and use_held clears.
- rst mid-stall: use_held clears. The held word is discarded and the first post-reset output is NOP_INST.
- valid_f=0 on advance: the slot becomes invalid and inst_d=NOP_INST. pc_d still loads pc_f.
- No combinational path from en, clear or valid_f to any output.

Test Plan:
- Reset: hold rst 2 cycles, then release with en=1, valid_f=1, pc_f=0x0, imem_rdata=0x00500093.
  - During reset: inst_d=0x00000013, valid_d=0, pc_d=0, stall_cnt=0.
  - One edge after release: inst_d=0x00500093, pc_d=0.
- Streaming: pc_f=0,4,8 on consecutive edges, memory returns 0x00500093, 0xFE010113, 0x00C12023.
  - inst_d and pc_d follow with 1-cycle alignment.
  - Immediate-unit input inst_d[31:7] matches each word.
- Stall hold: advance to pc_d=0x4 (0xFE010113), then en=0 for 3 edges while imem_rdata changes to 0x00C12023, then 0xDEADBEEF.
  - inst_d stays 0xFE010113 and pc_d stays 0x4 throughout.
  - stall_cnt=3.
  - On the next edge with en=1: use_held=0, inst_d=imem_rdata.
- Flush: clear=1 with en=1 while pc_d=0x8.
  - Next cycle: inst_d=0x00000013, valid_d=0, pc_d=0.
  - The following advance with valid_f=1, pc_f=0x40 gives pc_d=0x40.
- Flush during stall: en=0 for 2 edges, then clear=1 with en=0.
  - Slot empties, stall_cnt frozen at 2, use_held=0.
  - Next advance loads the live word.
- Saturation and reset mid-stall: with CNT_W=4, stall 20 edges.
  - stall_cnt=15 and stays there.
  - Assert rst during the stall: stall_cnt=0, valid_d=0, inst_d=0x00000013.

Source files
------------

// File: rtl/id_inst_hold_buffer.sv
// IF/ID hold buffer between a synchronous-read instruction memory and decode.
// The memory output moves one cycle after its address, so a stalled decode
// slot keeps its own copy of the word. Empty slots present a NOP. A saturating
// counter records stalled decode cycles for debug.
module id_inst_hold_buffer #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [31:0]      pc_f,
    input  logic             valid_f,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst_d,
    output logic [31:0]      pc_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0] held_inst;
    logic        use_held;

    // A stalled decode slot: valid instruction, not flushed, not advancing.
    logic stall_edge;
    assign stall_edge = valid_d & ~clear & ~en;

    // Slot control: flush beats advance, advance beats hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_d      <= '0;
            valid_d   <= 1'b0;
            use_held  <= 1'b0;
            held_inst <= '0;
        end else if (clear) begin
            pc_d     <= '0;
            valid_d  <= 1'b0;
            use_held <= 1'b0;
        end else if (en) begin
            pc_d     <= pc_f;
            valid_d  <= valid_f;
            use_held <= 1'b0;
        end else if (!use_held) begin
            // First stalled edge: grab the live word before the RAM output
            // moves on; later stalled edges leave the copy alone.
            held_inst <= imem_rdata;
            use_held  <= 1'b1;
        end
    end

    // Saturating count of stalled decode cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_edge && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Decode instruction: NOP when empty, held copy while stalled, else the
    // live memory word. Depends only on state and imem_rdata.
    always_comb begin
        inst_d = NOP_INST;
        if (valid_d) begin
            inst_d = use_held ? held_inst : imem_rdata;
        end
    end

endmodule
